data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
- Next-generation data memory for the single-cycle and pipelined RV32 datapaths.
- Adds the following over the plain word store:
  - request/response handshake
  - configurable read latency
  - byte/halfword/word stores with byte lanes
  - sub-word loads with sign/zero extension
  - fault reporting for misaligned, out-of-range and illegal-size accesses
- Sits between the core's MEM stage and the on-chip RAM array; one access per cycle, in-order responses.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1, cycles from request accept to response; 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  1  access request
- req_ready  output  1  block can accept this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  size/sign code, RV32 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response pulse, one per accepted request
- rsp_we  output  1  echo of req_we for this response
- rsp_rdata  output  32  load result, extended; 0 for stores and faults
- rsp_err  output  1  access faulted; no memory side-effect
- busy  output  1  at least one request in flight

Behaviour:
- Accept when req_valid && req_ready.
  - req_ready is 0 while rst is asserted and 1 otherwise. There is no backpressure on responses.
- Reset: rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0, busy=0, and all in-flight pipeline entries are cleared, all asynchronously.
  - RAM contents are not reset.
  - Requests in flight when rst asserts are dropped without a response. A store already committed stays committed.
- Word index = (req_addr - BASE_ADDR) >> 2; lane = req_addr[1:0].
- Fault checks, evaluated at accept, first match sets err:
  - funct3 illegal: 011, 110, 111, or 100/101 with req_we=1.
  - Misaligned: halfword with lane[0]=1, or word with lane!=0.
  - Out of range: req_addr < BASE_ADDR, or word index >= DEPTH.
- Faulted access: RAM is not written; the response carries err=1, rdata=0, and arrives with the same latency as a good access.
- Store:
  - Commits at the accept clock edge.
  - SB writes byte lane `lane` with wdata[7:0].
  - SH writes lanes lane and lane+1 with wdata[15:0].
  - SW writes all four lanes.
  - All other bytes are preserved (per-byte write enables).
  - Response after READ_LATENCY cycles with rsp_we=1, rdata=0.
- Load:
  - The RAM word is sampled at the accept edge.
  - The selected byte/halfword is extracted from `lane`.
  - Sign-extended for LB/LH, zero-extended for LBU/LHU.
  - rsp_valid is asserted exactly READ_LATENCY cycles after the accept edge and lasts one cycle.
- Back-to-back accepts every cycle are allowed. Responses come out in order, one per cycle.
- Same-cycle hazards and ordering:
  - Only one request exists per cycle, so there is no simultaneous read/write.
  - A store followed by a load to the same word on the next accept returns the new data.
- Pipeline:
  - A shift register of READ_LATENCY stages, each holding {valid, we, err, funct3, lane, word}.
  - The extend/format logic is applied at the last stage.
  - busy = OR of the stage valid bits.
- Address arithmetic is 32-bit unsigned. BASE_ADDR + DEPTH*4 wrapping past 2^32 is illegal and is rejected by an elaboration-time check.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - width localparams WORD_W=32, BYTES=4
  - typedef for the pipeline stage record
- Sub-module load_format (combinational): inputs are word, lane and funct3; output is the extended 32-bit result. It is shared with the future cache refill path.

Test Plan:
- SW 0x1122_3344 @0x10, then LW @0x10 at READ_LATENCY=1 -> rsp_valid one cycle after the load accept, rdata=0x11223344, err=0.
- SB 0xAB @0x13 over word 0x11223344, then LB @0x13 -> 0xFFFF_FFAB; LBU @0x13 -> 0x0000_00AB; LW @0x10 -> 0xAB223344.
- SH 0x8001 @0x12, then LH @0x12 -> 0xFFFF_8001; LHU -> 0x0000_8001; lower half unchanged.
- LW @0x11, SH @0x13, LW @DEPTH*4, funct3=011 -> each response err=1 and rdata=0; a subsequent LW shows RAM unchanged.
- READ_LATENCY=3, four back-to-back loads -> four consecutive rsp_valid cycles starting 3 cycles after the first accept, in order; busy high throughout.
- Assert rst with 2 loads in flight -> rsp_valid, busy and req_ready drop immediately with no further responses; after deassert a load returns pre-reset stored data.

Source files
------------

// File: rtl/data_memory_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data memory load/store unit.
//            RV32 funct3 size/sign codes, word geometry and the record
//            carried by each read-latency pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // One in-flight access. word holds the RAM word sampled at accept for a
  // good load and zero otherwise.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              err;
    logic [2:0]        funct3;
    logic [1:0]        lane;
    logic [WORD_W-1:0] word;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/data_memory_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_lsu_if
// Purpose  : Request/response bus between the core MEM stage (master) and the
//            data memory load/store unit (slave).
//            Request : req_valid, req_ready, req_we, req_funct3, req_addr,
//                      req_wdata
//            Response: rsp_valid, rsp_we, rsp_rdata, rsp_err
// Revision : 1.0 - initial release
// ============================================================================
interface data_memory_lsu_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/data_memory_lsu_load_format.sv
`default_nettype none
// ============================================================================
// Module   : load_format
// Purpose  : Combinational load extractor. Selects the byte/halfword at the
//            given lane of a RAM word and sign- or zero-extends it according
//            to the RV32 funct3 code. Unknown codes yield zero.
// Ports    : i_word   - 32-bit RAM word
//            i_lane   - byte lane (address bits [1:0])
//            i_funct3 - size/sign code
//            o_result - extended 32-bit load value
// Revision : 1.0 - initial release
// ============================================================================
module load_format
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  logic [2:0]        i_funct3,
  output logic [WORD_W-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[8*i_lane +: 8];
    // Halfword lanes are 0 or 2 for aligned accesses.
    w_half   = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_result = '0;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'd0, w_half};
      F3_W:    o_result = i_word;
      default: o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_lsu
// Purpose  : Data memory with request/response handshake, byte-lane stores,
//            sign/zero-extending sub-word loads, fault reporting and a
//            READ_LATENCY-deep in-order response pipeline.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - slave side of data_memory_lsu_if (request/response)
//            busy - at least one accepted request has not yet responded
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH        = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_lsu_if.slave   bus,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);

  // Elaboration-time parameter legality
  if ((DEPTH < 16) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_memory_lsu: DEPTH must be a power of two in 16..65536");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("data_memory_lsu: READ_LATENCY must be 1..4");
  end
  if ((BASE_ADDR & 32'(DEPTH * 4 - 1)) != 32'd0) begin : g_bad_align
    $error("data_memory_lsu: BASE_ADDR must be DEPTH*4 aligned");
  end
  if ((64'(BASE_ADDR) + 64'(DEPTH) * 64'd4) > 64'h1_0000_0000) begin : g_bad_wrap
    $error("data_memory_lsu: BASE_ADDR + DEPTH*4 wraps past 2^32");
  end

  logic [WORD_W-1:0] ram_q [DEPTH];
  stage_t            stage_q [READ_LATENCY];
  stage_t            stage_d [READ_LATENCY];

  logic [31:0]       offset;
  logic [1:0]        lane;
  logic [AW-1:0]     idx;
  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              wr_en;
  logic [BYTES-1:0]  be;
  logic [WORD_W-1:0] wdata_al;
  logic [WORD_W-1:0] fmt_data;

  assign bus.req_ready = ~rst;
  assign accept        = bus.req_valid & bus.req_ready;
  assign offset        = bus.req_addr - BASE_ADDR;
  // BASE_ADDR is word-aligned, so the offset's low bits are the byte lane.
  assign lane          = offset[1:0];
  assign idx           = offset[AW+1:2];

  always_comb begin
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = bus.req_we;
      default:          illegal = 1'b1;
    endcase
    misaligned   = (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && lane[0]) ||
                   ((bus.req_funct3 == F3_W) && (lane != 2'd0));
    // Any offset bit above the index range means the word index >= DEPTH.
    out_of_range = (bus.req_addr < BASE_ADDR) || (|offset[31:AW+2]);
    fault        = illegal | misaligned | out_of_range;
  end

  // Right-aligned store data is replicated across lanes; be picks the lanes.
  always_comb begin
    be       = '0;
    wdata_al = '0;
    case (bus.req_funct3)
      F3_B: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        be       = 4'b0011 << lane;
        wdata_al = {2{bus.req_wdata[15:0]}};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_al = bus.req_wdata;
      end
      default: begin
        be       = '0;
        wdata_al = '0;
      end
    endcase
    wr_en = accept & bus.req_we & ~fault;
  end

  // RAM array: not reset, per-byte write enables.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          ram_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    stage_d[0]        = '0;
    stage_d[0].valid  = accept;
    stage_d[0].we     = bus.req_we;
    stage_d[0].err    = fault;
    stage_d[0].funct3 = bus.req_funct3;
    stage_d[0].lane   = lane;
    stage_d[0].word   = (fault || bus.req_we) ? '0 : ram_q[idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  load_format u_load_format (
    .i_word   (stage_q[READ_LATENCY-1].word),
    .i_lane   (stage_q[READ_LATENCY-1].lane),
    .i_funct3 (stage_q[READ_LATENCY-1].funct3),
    .o_result (fmt_data)
  );

  // Outputs come straight from the last stage so reset clears them at once.
  always_comb begin
    bus.rsp_valid = stage_q[READ_LATENCY-1].valid;
    bus.rsp_we    = stage_q[READ_LATENCY-1].valid & stage_q[READ_LATENCY-1].we;
    bus.rsp_err   = stage_q[READ_LATENCY-1].valid & stage_q[READ_LATENCY-1].err;
    bus.rsp_rdata = (stage_q[READ_LATENCY-1].valid & ~stage_q[READ_LATENCY-1].we &
                     ~stage_q[READ_LATENCY-1].err) ? fmt_data : '0;
    busy          = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      busy = busy | stage_q[i].valid;
    end
  end

endmodule
`default_nettype wire
